char_buffer_wr_ctrl: RTL and testbench

- Write-side controller for the text character buffer; owns the buffer's wr_en / col_w / row_w / din write port.
- Arbitrates between two sources:
  - host character writes, via a valid/ready handshake;
  - a hardware clear engine that fills every cell with one character.
- Sits between the host/UART command path and the character buffer. The VGA read side is untouched.

---
 rtl/char_buffer_wr_ctrl.sv | 143 ++++++++++++++
 tb/tb_char_buffer_wr_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_wr_ctrl.sv
// Write-side controller for the text character buffer: arbitrates host
// character writes against a full-screen clear sweep onto one write port.
module char_buffer_wr_ctrl #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned COL_W  = 7,
  parameter int unsigned ROW_W  = 5,
  parameter int unsigned DATA_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hw_valid_i,
  output logic              hw_ready_o,
  input  logic [COL_W-1:0]  hw_col_i,
  input  logic [ROW_W-1:0]  hw_row_i,
  input  logic [DATA_W-1:0] hw_data_i,
  input  logic              clr_req_i,
  input  logic [DATA_W-1:0] clr_char_i,
  output logic              wr_en_o,
  output logic [COL_W-1:0]  col_w_o,
  output logic [ROW_W-1:0]  row_w_o,
  output logic [DATA_W-1:0] din_o,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              addr_err_o
);

  localparam logic [COL_W:0]   COLS_L   = (COL_W+1)'(COLS);
  localparam logic [ROW_W:0]   ROWS_L   = (ROW_W+1)'(ROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic                wr_en_d, clr_done_d, addr_err_d;
  logic [COL_W-1:0]    col_w_d;
  logic [ROW_W-1:0]    row_w_d;
  logic [DATA_W-1:0]   din_d;
  logic                host_fire_c;
  logic                host_in_range_c;
  logic                last_cell_c;

  // Clear request wins the cycle it arrives, so the host stalls instead of being lost
  assign hw_ready_o      = (state_q == S_IDLE) && !clr_req_i;
  assign busy_o          = (state_q == S_CLEAR);
  assign host_fire_c     = hw_valid_i && hw_ready_o;
  assign host_in_range_c = ({1'b0, hw_col_i} < COLS_L) && ({1'b0, hw_row_i} < ROWS_L);
  assign last_cell_c     = (col_q == LAST_COL) && (row_q == LAST_ROW);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req_i)   state_d = S_CLEAR;
      S_CLEAR: if (last_cell_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / sweep-counter logic; write-port fields hold when no write issues
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    fill_d     = fill_q;
    wr_en_d    = 1'b0;
    col_w_d    = col_w_o;
    row_w_d    = row_w_o;
    din_d      = din_o;
    clr_done_d = 1'b0;
    addr_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_req_i) begin
          fill_d = clr_char_i;
          col_d  = '0;
          row_d  = '0;
        end else if (host_fire_c) begin
          if (host_in_range_c) begin
            wr_en_d = 1'b1;
            col_w_d = hw_col_i;
            row_w_d = hw_row_i;
            din_d   = hw_data_i;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        wr_en_d    = 1'b1;
        col_w_d    = col_q;
        row_w_d    = row_q;
        din_d      = fill_q;
        clr_done_d = last_cell_c;
        if (last_cell_c) begin
          col_d = '0;
          row_d = '0;
        end else if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q      <= '0;
      row_q      <= '0;
      fill_q     <= '0;
      wr_en_o    <= 1'b0;
      col_w_o    <= '0;
      row_w_o    <= '0;
      din_o      <= '0;
      clr_done_o <= 1'b0;
      addr_err_o <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      fill_q     <= fill_d;
      wr_en_o    <= wr_en_d;
      col_w_o    <= col_w_d;
      row_w_o    <= row_w_d;
      din_o      <= din_d;
      clr_done_o <= clr_done_d;
      addr_err_o <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_char_buffer_wr_ctrl.sv
// Self-checking bench for char_buffer_wr_ctrl: table-driven host writes plus
// directed clear-sweep sequences, with a scoreboard queue of expected writes.
module tb_char_buffer_wr_ctrl;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned PW     = COL_W + ROW_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              hw_valid_i = 1'b0;
  logic              hw_ready_o;
  logic [COL_W-1:0]  hw_col_i = '0;
  logic [ROW_W-1:0]  hw_row_i = '0;
  logic [DATA_W-1:0] hw_data_i = '0;
  logic              clr_req_i = 1'b0;
  logic [DATA_W-1:0] clr_char_i = '0;
  logic              wr_en_o;
  logic [COL_W-1:0]  col_w_o;
  logic [ROW_W-1:0]  row_w_o;
  logic [DATA_W-1:0] din_o;
  logic              busy_o, clr_done_o, addr_err_o;

  char_buffer_wr_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .hw_valid_i(hw_valid_i), .hw_ready_o(hw_ready_o),
    .hw_col_i(hw_col_i), .hw_row_i(hw_row_i), .hw_data_i(hw_data_i),
    .clr_req_i(clr_req_i), .clr_char_i(clr_char_i),
    .wr_en_o(wr_en_o), .col_w_o(col_w_o), .row_w_o(row_w_o), .din_o(din_o),
    .busy_o(busy_o), .clr_done_o(clr_done_o), .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] data;
    logic              exp_wr;
    logic              exp_err;
  } vec_t;

  logic [PW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int s_cyc;
  logic s_wr, s_busy, s_done, s_err, s_ready, s_valid;
  logic [COL_W-1:0] s_col;
  logic [ROW_W-1:0] s_row;
  logic [DATA_W-1:0] s_din;
  int wr_count = 0, done_count = 0, err_count = 0, done_cyc = -1;
  int sweep_first = -1, sweep_last = -1, busy_first = -1, busy_last = -1;

  function automatic logic [PW-1:0] pack(input logic [COL_W-1:0] c,
                                         input logic [ROW_W-1:0] r,
                                         input logic [DATA_W-1:0] d);
    return {c, r, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample the current cycle at negedge, score writes, then advance one cycle
  task automatic tick();
    logic [PW-1:0] e;
    @(negedge clk);
    s_cyc = cyc; s_wr = wr_en_o; s_col = col_w_o; s_row = row_w_o; s_din = din_o;
    s_busy = busy_o; s_done = clr_done_o; s_err = addr_err_o;
    s_ready = hw_ready_o; s_valid = hw_valid_i;
    if (wr_en_o === 1'b1) begin
      wr_count++;
      if (sweep_first < 0) sweep_first = cyc;
      sweep_last = cyc;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got col=%0d row=%0d din=0x%0h expected none (cycle %0d)",
                 col_w_o, row_w_o, din_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wr_payload", 32'(pack(col_w_o, row_w_o, din_o)), 32'(e));
      end
    end
    if (busy_o === 1'b1) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (clr_done_o === 1'b1) begin
      done_count++;
      done_cyc = cyc;
      chk("done_busy_low", 32'(busy_o), 32'd0);
    end
    if (addr_err_o === 1'b1) err_count++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_clear(input logic [DATA_W-1:0] ch);
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++)
        exp_q.push_back(pack(COL_W'(c), ROW_W'(r), ch));
  endtask

  task automatic reset_sweep_marks();
    sweep_first = -1; sweep_last = -1; busy_first = -1; busy_last = -1;
  endtask

  vec_t vecs[10];
  int t0, base_wr, base_done, base_err, acc_cyc, guard;

  initial begin
    vecs[0] = '{1'b1, 7'd5,  5'd3,  7'h41, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 7'd0,  5'd0,  7'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 7'd0,  5'd0,  7'h10, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 7'd1,  5'd0,  7'h11, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 7'd2,  5'd0,  7'h12, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 7'd80, 5'd0,  7'h22, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 7'd0,  5'd0,  7'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 7'd0,  5'd30, 7'h23, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 7'd79, 5'd29, 7'h7f, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 7'd127,5'd31, 7'h01, 1'b0, 1'b1};

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_wr_en", 32'(s_wr), 32'd0);
    chk("rst_outs", 32'(pack(s_col, s_row, s_din)), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_flags", 32'({s_done, s_err}), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // Table-driven host writes: result of vector i is visible one cycle later
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        hw_valid_i = vecs[i].valid; hw_col_i = vecs[i].col;
        hw_row_i = vecs[i].row; hw_data_i = vecs[i].data;
        if (vecs[i].exp_wr) exp_q.push_back(pack(vecs[i].col, vecs[i].row, vecs[i].data));
      end else begin
        hw_valid_i = 1'b0;
      end
      tick();
      if (i < 10) chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("vec%0d_wr_en", i-1), 32'(s_wr), 32'(vecs[i-1].exp_wr));
        chk($sformatf("vec%0d_addr_err", i-1), 32'(s_err), 32'(vecs[i-1].exp_err));
      end
    end
    tick();
    chk("idle_after_vecs_wr", 32'(s_wr), 32'd0);
    chk("vec_queue_drained", 32'(exp_q.size()), 32'd0);

    // Full clear sweep with fill 0x20
    reset_sweep_marks();
    base_wr = wr_count; base_done = done_count;
    t0 = cyc;
    clr_req_i = 1'b1; clr_char_i = 7'h20;
    push_clear(7'h20);
    tick();
    chk("clr_req_ready_low", 32'(s_ready), 32'd0);
    clr_req_i = 1'b0; clr_char_i = 7'h00;
    for (int k = 0; k < int'(CELLS) + 2; k++) tick();
    chk("clr_write_count", 32'(wr_count - base_wr), 32'(CELLS));
    chk("clr_first_cycle", 32'(sweep_first - t0), 32'd2);
    chk("clr_last_cycle", 32'(sweep_last - t0), 32'(CELLS + 1));
    chk("clr_done_count", 32'(done_count - base_done), 32'd1);
    chk("clr_done_cycle", 32'(done_cyc - t0), 32'(CELLS + 1));
    chk("clr_busy_first", 32'(busy_first - t0), 32'd1);
    chk("clr_busy_last", 32'(busy_last - t0), 32'(CELLS));
    chk("clr_queue_drained", 32'(exp_q.size()), 32'd0);

    // Clear and host write together; second clear mid-sweep must be ignored
    reset_sweep_marks();
    base_wr = wr_count; base_done = done_count;
    t0 = cyc; acc_cyc = -1;
    clr_req_i = 1'b1; clr_char_i = 7'h2a;
    hw_valid_i = 1'b1; hw_col_i = 7'd10; hw_row_i = 5'd10; hw_data_i = 7'h55;
    push_clear(7'h2a);
    exp_q.push_back(pack(7'd10, 5'd10, 7'h55));
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (s_valid && s_ready) begin
        acc_cyc = s_cyc;
        break;
      end
      clr_req_i = (k == 999);
      clr_char_i = (k == 999) ? 7'h33 : 7'h00;
    end
    hw_valid_i = 1'b0;
    clr_req_i = 1'b0;
    chk("host_accept_cycle", 32'(acc_cyc - t0), 32'(CELLS + 1));
    tick(); tick();
    chk("host_write_cycle", 32'(sweep_last - t0), 32'(CELLS + 2));
    chk("contend_write_count", 32'(wr_count - base_wr), 32'(CELLS + 1));
    chk("contend_done_count", 32'(done_count - base_done), 32'd1);
    chk("contend_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in mid-sweep, right as cell 500 is presented
    base_wr = wr_count; base_done = done_count;
    clr_req_i = 1'b1; clr_char_i = 7'h2e;
    push_clear(7'h2e);
    tick();
    clr_req_i = 1'b0;
    guard = 0;
    while ((wr_count - base_wr) < 500 && guard < 1000) begin
      tick();
      guard++;
    end
    chk("abort_wait_timeout", 32'(guard < 1000), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("abort_writes_before", 32'(wr_count - base_wr), 32'd501);
    chk("abort_queue_left", 32'(exp_q.size()), 32'(CELLS - 501));
    exp_q.delete();
    tick();
    chk("abort_wr_en", 32'(s_wr), 32'd0);
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd1);
    tick(); tick();
    chk("abort_no_done", 32'(done_count - base_done), 32'd0);

    // Host write after abort behaves normally
    base_err = err_count;
    hw_valid_i = 1'b1; hw_col_i = 7'd3; hw_row_i = 5'd4; hw_data_i = 7'h61;
    exp_q.push_back(pack(7'd3, 5'd4, 7'h61));
    tick();
    chk("post_abort_ready", 32'(s_ready), 32'd1);
    hw_valid_i = 1'b0;
    tick();
    chk("post_abort_wr_en", 32'(s_wr), 32'd1);
    tick();
    chk("post_abort_idle", 32'(s_wr), 32'd0);
    chk("post_abort_no_err", 32'(err_count - base_err), 32'd0);
    chk("post_abort_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
